// File: rtl/time_setter_pkg.sv
// Shared widths, limits, packing offsets and FSM encoding for the time setter.
// Field helpers keep every value inside its legal range.
package time_setter_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int TIME_W = HOUR_W + MIN_W + SEC_W;

  localparam int SEC_LSB  = 0;
  localparam int MIN_LSB  = SEC_LSB + SEC_W;
  localparam int HOUR_LSB = MIN_LSB + MIN_W;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MS_MAX   = 6'd59;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SET_H,
    SET_M,
    SET_S,
    HOLD
  } state_t;

  function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
    return (h >= HOUR_MAX) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [HOUR_W-1:0] hour_dec(input logic [HOUR_W-1:0] h);
    return (h == '0 || h > HOUR_MAX) ? HOUR_MAX : h - 1'b1;
  endfunction

  function automatic logic [MIN_W-1:0] ms_inc(input logic [MIN_W-1:0] v);
    return (v >= MS_MAX) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [MIN_W-1:0] ms_dec(input logic [MIN_W-1:0] v);
    return (v == '0 || v > MS_MAX) ? MS_MAX : v - 1'b1;
  endfunction

  // A corrupt value from the clock core is loaded as zero rather than kept.
  function automatic logic [HOUR_W-1:0] hour_clamp(input logic [HOUR_W-1:0] h);
    return (h > HOUR_MAX) ? '0 : h;
  endfunction

  function automatic logic [MIN_W-1:0] ms_clamp(input logic [MIN_W-1:0] v);
    return (v > MS_MAX) ? '0 : v;
  endfunction

endpackage

// File: rtl/time_setter_btn_edge.sv
// Two-flop synchronizer plus registered rising-edge pulse for one button.
// Pulse appears three clocks after the input edge and lasts one cycle.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [2:0] warm_q;

  // warm_q masks the edge detector until the synchronizer holds the real
  // button level, so a button held through reset release never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      warm_q <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      prev_q <= sync_q[1];
      warm_q <= {warm_q[1:0], 1'b1};
      pulse  <= warm_q[2] & sync_q[1] & ~prev_q;
    end
  end

endmodule

// File: rtl/time_setter.sv
// Button-driven time editor: captures the running time, edits h/m/s with
// wrap-around, and holds the overwrite request long enough to be committed.
module time_setter
  import time_setter_pkg::*;
#(
  parameter int OW_HOLD = 100000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [TIME_W-1:0] time_cur,
  output logic [TIME_W-1:0] time_in,
  output logic              time_ow,
  output logic [1:0]        edit_field
);

  localparam int CNT_W = (OW_HOLD > 1) ? $clog2(OW_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OW_HOLD - 1);

  logic ev_mode, ev_inc, ev_dec;
  logic step_up, step_dn;

  state_t            state;
  logic [HOUR_W-1:0] hour_q;
  logic [MIN_W-1:0]  min_q;
  logic [SEC_W-1:0]  sec_q;
  logic [CNT_W-1:0]  cnt_q;

  btn_edge u_edge_mode (.clk(clk), .rst(rst), .btn(btn_mode), .pulse(ev_mode));
  btn_edge u_edge_inc  (.clk(clk), .rst(rst), .btn(btn_inc),  .pulse(ev_inc));
  btn_edge u_edge_dec  (.clk(clk), .rst(rst), .btn(btn_dec),  .pulse(ev_dec));

  // Mode wins over inc/dec; simultaneous inc and dec cancel.
  assign step_up = ev_inc & ~ev_dec & ~ev_mode;
  assign step_dn = ev_dec & ~ev_inc & ~ev_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hour_q <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_mode) begin
            hour_q <= hour_clamp(time_cur[HOUR_LSB +: HOUR_W]);
            min_q  <= ms_clamp(time_cur[MIN_LSB +: MIN_W]);
            sec_q  <= ms_clamp(time_cur[SEC_LSB +: SEC_W]);
            state  <= SET_H;
          end
        end
        SET_H: begin
          if (ev_mode)      state  <= SET_M;
          else if (step_up) hour_q <= hour_inc(hour_q);
          else if (step_dn) hour_q <= hour_dec(hour_q);
        end
        SET_M: begin
          if (ev_mode)      state <= SET_S;
          else if (step_up) min_q <= ms_inc(min_q);
          else if (step_dn) min_q <= ms_dec(min_q);
        end
        SET_S: begin
          if (ev_mode) begin
            state <= HOLD;
            cnt_q <= CNT_LOAD;
          end else if (step_up) begin
            sec_q <= ms_inc(sec_q);
          end else if (step_dn) begin
            sec_q <= ms_dec(sec_q);
          end
        end
        HOLD: begin
          if (cnt_q == '0) state <= IDLE;
          else             cnt_q <= cnt_q - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly so reset drops them at once.
  always_comb begin
    time_ow    = 1'b0;
    edit_field = FIELD_NONE;
    case (state)
      SET_H: begin time_ow = 1'b1; edit_field = FIELD_HOUR; end
      SET_M: begin time_ow = 1'b1; edit_field = FIELD_MIN;  end
      SET_S: begin time_ow = 1'b1; edit_field = FIELD_SEC;  end
      HOLD:  time_ow = 1'b1;
      default: ;
    endcase
  end

  assign time_in = {hour_q, min_q, sec_q};

endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 SHALL have parameter OW_HOLD, default 100000000: clk cycles time_ow stays high after commit; must be at least one 1 Hz period.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port btn_mode, input, 1: debounced level, asynchronous to clk.
REQ-005 SHALL have port btn_inc, input, 1: debounced level, asynchronous to clk.
REQ-006 SHALL have port btn_dec, input, 1: debounced level, asynchronous to clk.
REQ-007 SHALL have port time_cur, input, 17: running time from the clock core, packed {hour[4:0], min[5:0], sec[5:0]}.
REQ-008 SHALL have port time_in, output, 17: value to load into the clock core, same packing.
REQ-009 SHALL have port time_ow, output, 1: overwrite request to the clock core.
REQ-010 SHALL have port edit_field, output, 2: 0 none, 1 hour, 2 min, 3 sec (display blink select).

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer and a rising-edge detector; one press = one single-cycle event, 3-cycle latency from input edge.
REQ-012 SHALL implement FSM states IDLE, SET_H, SET_M, SET_S, HOLD.
REQ-013 IDLE: time_ow=0, edit_field=0, time_in = edit register; inc/dec events ignored.
REQ-014 IDLE + mode event SHALL capture time_cur into the edit register and go to SET_H.
REQ-015 SET_H -> SET_M -> SET_S on mode events; SET_S + mode event -> HOLD and load counter with OW_HOLD-1.
REQ-016 In SET_H/SET_M/SET_S, time_ow SHALL be 1 and time_in SHALL equal the edit register, combinationally from state.
REQ-017 inc on the selected field SHALL add 1, wrapping hour 23->0 and min/sec 59->0.
REQ-018 dec on the selected field SHALL subtract 1, wrapping hour 0->23 and min/sec 0->59.
REQ-019 Unselected fields SHALL never change while editing.
REQ-020 Same-cycle inc and dec events SHALL be ignored.
REQ-021 A mode event in the same cycle as inc/dec SHALL advance state only; the field is not modified.
REQ-022 HOLD: time_ow=1, edit_field=0; counter decrements each cycle; at 0 return to IDLE with time_ow=0 next cycle.
REQ-023 HOLD SHALL ignore all button events.
REQ-024 Field arithmetic SHALL be at native width (5/6 bits); the register SHALL never hold out-of-range values (hour>23, min/sec>59).

Reset
REQ-025 rst SHALL immediately force the IDLE state, edit register 0, counter 0, synchronizer and edge flops 0, time_ow=0, edit_field=0, time_in=0.
REQ-026 Reset mid-edit or mid-HOLD SHALL drop time_ow at once without committing; the clock core keeps its current time.
REQ-027 A button held high through reset release SHALL NOT generate an event.

Structure
REQ-028 A shared package SHALL hold the field widths (5, 6, 6), the maxima HOUR_MAX=23 and MS_MAX=59, the 17-bit time packing offsets, and the FSM state enum.
REQ-029 SHALL instantiate sub-module btn_edge (2-flop sync + rising-edge pulse) three times; FSM and field arithmetic stay in time_setter.

Verification (OW_HOLD=4 in bench)
REQ-030 Bench SHALL cover: time_cur=12:34:56, mode press -> SET_H, time_ow=1, time_in=12:34:56, edit_field=1.
REQ-031 Bench SHALL cover: in SET_H with hour=23, inc -> hour=0; dec -> 23; min/sec unchanged.
REQ-032 Bench SHALL cover: in SET_M with min=0, dec -> 59; in SET_S with sec=59, inc -> 0.
REQ-033 Bench SHALL cover: mode from SET_S -> time_ow high exactly 4 more cycles in HOLD, then low in IDLE, time_in held.
REQ-034 Bench SHALL cover: inc and dec pressed in the same cycle in SET_M -> no change; mode and inc together -> SET_S, min unchanged.
REQ-035 Bench SHALL cover: rst pulse during SET_M -> time_ow and edit_field 0 the same cycle, state IDLE, no commit.
